// File: rtl/nn_stream_pkg.sv
// Shared types and constants for the table-driven stream player.
package nn_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NN_DEF_WIDTH = 32;
  localparam int NN_DEF_DEPTH = 64;

  // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register:
  // feedback is the XOR of bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/nn_stream_lfsr.sv
// 16-bit throttle LFSR: reloads the seed on load_i, advances on step_i.
module nn_stream_lfsr
  import nn_stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Seed reload takes priority so every playback sees the same gap pattern.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = LFSR_SEED;
    else if (step_i) lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/nn_stream_player.sv
// Table-driven stream player: plays table[0..len-1] for a number of passes
// over a valid/ready output with registered data and first-of-frame flag.
// Optional macro NN_STREAM_PLAYER_THROTTLE_EN adds LFSR-gated word issue.
module nn_stream_player
  import nn_stream_pkg::*;
#(
  parameter  int WIDTH = NN_DEF_WIDTH,
  parameter  int DEPTH = NN_DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic [LW-1:0]    cfg_length,
  input  logic [LW-1:0]    cfg_frame_len,
  input  logic [15:0]      cfg_loops,
`ifdef NN_STREAM_PLAYER_THROTTLE_EN
  input  logic             throttle_en,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_fst,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done,
  output logic [31:0]      word_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [LW-1:0]    len_q, len_d, frm_q, frm_d, fcnt_q, fcnt_d;
  logic [15:0]      loops_q, loops_d, pass_q, pass_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             more_q, more_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fst_q, fst_d, vld_q, vld_d;
  logic [31:0]      wc_q, wc_d;

  // Load-side view: on an accepted start the fresh cfg replaces the captured one.
  logic             go, xfer, gate, do_load;
  logic [LW-1:0]    l_len, l_frm, l_fcnt;
  logic [15:0]      l_loops, l_pass, l_pnext;
  logic [AW-1:0]    l_idx;
  logic             l_wrap, l_last, l_fst;

`ifdef NN_STREAM_PLAYER_THROTTLE_EN
  logic        thr_q, thr_d;
  logic [15:0] lfsr;

  nn_stream_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (go),
    .step_i  (state_q == ST_RUN),
    .state_o (lfsr)
  );

  assign gate = ~thr_q | lfsr[0];
`else
  assign gate = 1'b1;
`endif

  // Table write port; addresses beyond DEPTH match no entry and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (wr_en && wr_addr == AW'(i)) mem_q[i] <= wr_data;
  end

  // Next-state, word issue and transfer bookkeeping.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    frm_d   = frm_q;
    fcnt_d  = fcnt_q;
    loops_d = loops_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    more_d  = more_q;
    last_d  = last_q;
    data_d  = data_q;
    fst_d   = fst_q;
    vld_d   = vld_q;
    wc_d    = wc_q;
`ifdef NN_STREAM_PLAYER_THROTTLE_EN
    thr_d   = thr_q;
`endif

    go      = start & ~abort & (state_q != ST_RUN);
    xfer    = vld_q & out_rdy;
    l_len   = go ? cfg_length    : len_q;
    l_frm   = go ? cfg_frame_len : frm_q;
    l_loops = go ? cfg_loops     : loops_q;
    l_idx   = go ? '0            : idx_q;
    l_fcnt  = go ? '0            : fcnt_q;
    l_pass  = go ? '0            : pass_q;
    l_wrap  = ({1'b0, l_idx} == l_len - LW'(1));
    l_pnext = l_pass + 16'd1;
    l_last  = l_wrap && (l_loops != '0) && (l_pnext == l_loops);
    l_fst   = (l_idx == '0) || ((l_frm != '0) && (l_fcnt == '0));
    do_load = go ? (cfg_length != '0)
                 : ((state_q == ST_RUN) && more_q && (~vld_q | out_rdy) && gate);

    if (xfer) begin
      vld_d = 1'b0;
      wc_d  = (wc_q == 32'hFFFF_FFFF) ? wc_q : wc_q + 32'd1;
      if (last_q) state_d = ST_DONE;
    end

    if (go) begin
      state_d = (cfg_length == '0) ? ST_DONE : ST_RUN;
      len_d   = cfg_length;
      frm_d   = cfg_frame_len;
      loops_d = cfg_loops;
      idx_d   = '0;
      fcnt_d  = '0;
      pass_d  = '0;
      more_d  = 1'b0;
      last_d  = 1'b0;
      vld_d   = 1'b0;
      wc_d    = '0;
`ifdef NN_STREAM_PLAYER_THROTTLE_EN
      thr_d   = throttle_en;
`endif
    end

    if (do_load) begin
      data_d = mem_q[l_idx];
      fst_d  = l_fst;
      vld_d  = 1'b1;
      last_d = l_last;
      more_d = ~l_last;
      if (l_wrap) begin
        idx_d  = '0;
        fcnt_d = '0;
        pass_d = l_pnext;
      end else begin
        idx_d  = l_idx + AW'(1);
        fcnt_d = (l_fcnt + LW'(1) == l_frm) ? '0 : l_fcnt + LW'(1);
      end
    end

    if (abort) begin
      state_d = ST_IDLE;
      vld_d   = 1'b0;
      more_d  = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      frm_q   <= '0;
      fcnt_q  <= '0;
      loops_q <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      more_q  <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      fst_q   <= 1'b0;
      vld_q   <= 1'b0;
      wc_q    <= '0;
`ifdef NN_STREAM_PLAYER_THROTTLE_EN
      thr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      frm_q   <= frm_d;
      fcnt_q  <= fcnt_d;
      loops_q <= loops_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      more_q  <= more_d;
      last_q  <= last_d;
      data_q  <= data_d;
      fst_q   <= fst_d;
      vld_q   <= vld_d;
      wc_q    <= wc_d;
`ifdef NN_STREAM_PLAYER_THROTTLE_EN
      thr_q   <= thr_d;
`endif
    end
  end

  assign out_data   = data_q;
  assign out_fst    = fst_q;
  assign out_vld    = vld_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign word_count = wc_q;

endmodule

// File: doc/nn_stream_player.md
NN_STREAM_PLAYER -- requirements
Module: nn_stream_player

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter DEPTH, default 64, table entries; AW = clog2(DEPTH).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Ports wr_en/wr_addr/wr_data  input  1/AW/WIDTH  table write port, one word per cycle.
REQ-006 Ports start/abort  input  1/1  start a playback / cancel a playback.
REQ-007 Ports cfg_length/cfg_frame_len/cfg_loops  input  AW+1/AW+1/16  words per pass, words per frame, pass count (0 = infinite).
REQ-008 Ports out_data/out_fst/out_vld  output  WIDTH/1/1  stream word, first-of-frame flag, valid.
REQ-009 Port out_rdy  input  1  sink ready; a transfer occurs when out_vld & out_rdy.
REQ-010 Ports busy/done/word_count  output  1/1/32  playing, playback complete (sticky), transfers since start.

Function
REQ-011 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the transfer of the last word of the last pass; DONE->RUN on start; any state->IDLE on abort.
REQ-012 cfg_* are captured on the start cycle; changes during RUN have no effect.
REQ-013 cfg_length = 0 at start: go directly to DONE; no out_vld.
REQ-014 start while in RUN is ignored; abort and start in the same cycle: abort wins.
REQ-015 out_data/out_fst/out_vld are registered; first out_vld one cycle after start.
REQ-016 While out_vld & ~out_rdy, out_data, out_fst and out_vld hold stable.
REQ-017 Index advances on each transfer; after index cfg_length-1 it wraps to 0 and the pass counter increments.
REQ-018 out_fst is 1 at index 0 of every pass and every cfg_frame_len words after it within the pass; cfg_frame_len = 0 means index 0 only.
REQ-019 With cfg_loops = 0, playback never reaches DONE; only abort ends it.
REQ-020 word_count clears on start, increments per transfer, and saturates at 32'hFFFFFFFF.
REQ-021 A table write during RUN is permitted; a word already loaded into the output register is not changed.
REQ-022 A write to a wr_addr >= DEPTH is dropped.
REQ-023 On abort, out_vld drops the next cycle, and done and busy are 0.
REQ-024 busy = (state == RUN); done = (state == DONE).

Reset
REQ-025 Reset gives state IDLE, out_vld 0, out_fst 0, out_data 0, word_count 0, and all counters 0.
REQ-026 Table contents are not reset; reset during RUN aborts the playback immediately.

Configuration
REQ-027 Macro NN_STREAM_PLAYER_THROTTLE_EN adds input throttle_en (1 bit, captured at start).
REQ-028 With the macro and throttle_en = 1, a new word is presented only when the LFSR bit 0 is 1.
  - Polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1.
  - The LFSR steps every RUN cycle.
  - A word already valid is never withdrawn.
REQ-029 Without the macro, no throttle port or LFSR exists; a word is presented whenever the output register is empty or is being transferred.

Structure
REQ-030 Shared package nn_stream_pkg holds the state enum, the LFSR seed and taps, and the default WIDTH/DEPTH constants.
REQ-031 LFSR is sub-module nn_stream_lfsr, instantiated only under NN_STREAM_PLAYER_THROTTLE_EN.
REQ-032 Table is an inferred register array with an asynchronous read feeding the output register.

Verification
REQ-033 Load 0..35 with 32'h3F800000+i; length 36, frame_len 0, loops 2, out_rdy = 1 -> 72 words, fst at words 0 and 36, done after word 71, word_count 72.
REQ-034 length 12, frame_len 4, loops 1 -> fst on indices 0, 4, 8 only.
REQ-035 out_rdy toggling 1010... -> data and fst stable while stalled; sequence identical to the out_rdy = 1 case.
REQ-036 loops 0, abort at cycle 500 -> out_vld 0 at cycle 501, state IDLE, done 0; a new start replays from index 0.
REQ-037 cfg_length 0 -> done the cycle after start with no out_vld; reset asserted mid-RUN -> all outputs at reset values.
REQ-038 With NN_STREAM_PLAYER_THROTTLE_EN and throttle_en = 1 -> the same word sequence as REQ-033, with gaps matching the LFSR bit-0 pattern from seed ACE1.
